aphase_sel_sched: RTL and testbench

Round-robin scheduler that shares the 4-way A-phase pattern mux between four requesters. It arbitrates requests, drives the mux 2-bit select, waits out the mux's one-cycle registered-select latency, then holds the grant for a programmable dwell before releasing. It sits directly upstream of the pattern mux and owns its select input; requesters see a one-hot grant plus a valid flag that marks when the mux output carries their pattern.

---
 rtl/aphase_pkg.sv | 24 ++
 rtl/aphase_rr_pick.sv | 27 ++
 rtl/aphase_sel_sched.sv | 136 +++++++++++++
 tb/tb_aphase_sel_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/aphase_pkg.sv
// Shared types and constants for the A-phase pattern mux scheduler.
package aphase_pkg;

    localparam int unsigned NumReq = 4;
    localparam int unsigned SelW   = 2;

    // FSM state encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;

    // Patterns presented on mux inputs 3..0 (index 0 is the rightmost element).
    localparam logic [NumReq-1:0][9:0] ApPatterns = {
        10'b0101010101,
        10'b1010101010,
        10'b1111000011,
        10'b1001011010
    };

    function automatic logic [NumReq-1:0] sel_onehot(input logic [SelW-1:0] sel);
        return NumReq'(1) << sel;
    endfunction

endpackage

// File: rtl/aphase_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping 3->0.
module aphase_rr_pick
    import aphase_pkg::*;
(
    input  logic [NumReq-1:0] req_i,
    input  logic [SelW-1:0]   ptr_i,
    output logic [SelW-1:0]   winner_o,
    output logic              found_o
);

    logic [SelW-1:0] idx;

    // Scan from the farthest offset back to the pointer so the nearest request wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = ptr_i + SelW'(i);
            if (req_i[idx]) begin
                winner_o = idx;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aphase_sel_sched.sv
// Round-robin scheduler owning the A-phase pattern mux select.
// Optional grant extension input ilock is built in with APHASE_SCHED_LOCK_EN.
module aphase_sel_sched
    import aphase_pkg::*;
#(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned SETTLE  = 1
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               ienable,
    input  logic [NumReq-1:0]  ireq,
    input  logic [DWELL_W-1:0] idwell,
`ifdef APHASE_SCHED_LOCK_EN
    input  logic               ilock,
`endif
    output logic [SelW-1:0]    oslt,
    output logic [NumReq-1:0]  ogrant,
    output logic               ovalid,
    output logic               odone
);

    localparam logic [1:0] SettleInit = 2'(SETTLE);

    logic [1:0]         state_q, state_d;
    logic [SelW-1:0]    slt_q, slt_d;
    logic [NumReq-1:0]  grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [SelW-1:0]    ptr_q, ptr_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         settle_q, settle_d;

    logic [SelW-1:0] winner;
    logic            found;
    logic            req_held;
    logic            lock_now;

    aphase_rr_pick u_pick (
        .req_i    (ireq),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    assign req_held = ireq[slt_q];
`ifdef APHASE_SCHED_LOCK_EN
    assign lock_now = ilock & req_held;
`else
    assign lock_now = 1'b0;
`endif

    // odone is registered, so the final-cycle decision (and lock) is taken one cycle ahead.
    always_comb begin
        state_d  = state_q;
        slt_d    = slt_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        ptr_d    = ptr_q;
        dwell_d  = dwell_q;
        settle_d = settle_q;
        unique case (state_q)
            StIdle: begin
                if (ienable && found) begin
                    slt_d    = winner;
                    grant_d  = sel_onehot(winner);
                    dwell_d  = (idwell == '0) ? DWELL_W'(1) : idwell;
                    settle_d = SettleInit;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                settle_d = settle_q - 2'd1;
                if (!req_held) begin
                    state_d = StIdle;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = slt_q + SelW'(1);
                end else if (settle_q == 2'd1) begin
                    state_d = StHold;
                    valid_d = 1'b1;
                    done_d  = (dwell_q == DWELL_W'(1)) && !lock_now;
                end
            end
            StHold: begin
                if (done_q || !req_held) begin
                    // Completion wins over a same-cycle request drop.
                    state_d = StIdle;
                    grant_d = '0;
                    valid_d = 1'b0;
                    dwell_d = '0;
                    ptr_d   = slt_q + SelW'(1);
                end else if (dwell_q > DWELL_W'(1)) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                    done_d  = (dwell_q == DWELL_W'(2)) && !lock_now;
                end else begin
                    done_d = !lock_now;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= StIdle;
            slt_q    <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ptr_q    <= '0;
            dwell_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            slt_q    <= slt_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            dwell_q  <= dwell_d;
            settle_q <= settle_d;
        end
    end

    assign oslt   = slt_q;
    assign ogrant = grant_q;
    assign ovalid = valid_q;
    assign odone  = done_q;

endmodule

// File: tb/tb_aphase_sel_sched.sv
// Directed scoreboard bench for aphase_sel_sched (SETTLE=1, DWELL_W=8).
module tb_aphase_sel_sched;

    logic       iclk;
    logic       irst_n;
    logic       ienable;
    logic [3:0] ireq;
    logic [7:0] idwell;
`ifdef APHASE_SCHED_LOCK_EN
    logic       ilock;
`endif
    logic [1:0] oslt;
    logic [3:0] ogrant;
    logic       ovalid;
    logic       odone;

    int vectors;
    int miscompares;
    logic [7:0] exp_q[$];

    aphase_sel_sched #(
        .DWELL_W (8),
        .SETTLE  (1)
    ) dut (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .ienable (ienable),
        .ireq    (ireq),
        .idwell  (idwell),
`ifdef APHASE_SCHED_LOCK_EN
        .ilock   (ilock),
`endif
        .oslt    (oslt),
        .ogrant  (ogrant),
        .ovalid  (ovalid),
        .odone   (odone)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Expected output word: {grant, slt, valid, done}
    task automatic push(input logic [3:0] g, input logic [1:0] s, input logic v, input logic d);
        exp_q.push_back({g, s, v, d});
    endtask

    task automatic compare(input string tag);
        logic [7:0] obs;
        logic [7:0] e;
        obs = {ogrant, oslt, ovalid, odone};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed %b required <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed g=%b s=%0d v=%b d=%b required g=%b s=%0d v=%b d=%b",
                       tag, obs[7:4], obs[3:2], obs[1], obs[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input logic d);
        push(g, s, v, d);
        @(posedge iclk);
        #1;
        compare(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        irst_n  = 1'b0;
        ienable = 1'b0;
        ireq    = 4'b0000;
        idwell  = 8'd0;
`ifdef APHASE_SCHED_LOCK_EN
        ilock   = 1'b0;
`endif
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0);
        compare("reset_state");
        @(posedge iclk);
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        step("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request to input 2, dwell 3; request falls in the final valid cycle.
        ienable = 1'b1;
        ireq    = 4'b0100;
        idwell  = 8'd3;
        step("single_grant", 4'b0100, 2'd2, 1'b0, 1'b0);
        step("single_hold1", 4'b0100, 2'd2, 1'b1, 1'b0);
        step("single_hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step("single_done", 4'b0100, 2'd2, 1'b1, 1'b1);
        ireq = 4'b0000;
        step("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        step("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Mid-HOLD asynchronous reset (pointer is now 3, so 0100 still wins input 2).
        ireq   = 4'b0100;
        idwell = 8'd5;
        step("rst_grant", 4'b0100, 2'd2, 1'b0, 1'b0);
        step("rst_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        #3;
        irst_n = 1'b0;
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0);
        compare("rst_async");
        ireq = 4'b0000;
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        step("rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Round robin from pointer 0 with all requesting, dwell 1: period 3.
        ireq   = 4'b1111;
        idwell = 8'd1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] w;
            logic [3:0] oh;
            w  = 2'(k);
            oh = 4'b0001 << w;
            step($sformatf("rr_grant%0d", k), oh, w, 1'b0, 1'b0);
            step($sformatf("rr_valid%0d", k), oh, w, 1'b1, 1'b1);
            if (k == 4) ireq = 4'b0000;
            step($sformatf("rr_idle%0d", k), 4'b0000, w, 1'b0, 1'b0);
        end

        // Abort: pointer is 1; requester 1 drops in its second HOLD cycle.
        ireq   = 4'b0110;
        idwell = 8'd5;
        step("abort_grant", 4'b0010, 2'd1, 1'b0, 1'b0);
        step("abort_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step("abort_hold2", 4'b0010, 2'd1, 1'b1, 1'b0);
        ireq = 4'b0100;
        step("abort_clear", 4'b0000, 2'd1, 1'b0, 1'b0);
        // Requester 1 back: pointer already moved past it, so input 2 wins.
        ireq   = 4'b0110;
        idwell = 8'd0;
        step("abort_next", 4'b0100, 2'd2, 1'b0, 1'b0);
        step("dwell0_valid", 4'b0100, 2'd2, 1'b1, 1'b1);
        ienable = 1'b0;
        step("dwell0_end", 4'b0000, 2'd2, 1'b0, 1'b0);
        ireq = 4'b1111;
        for (int k = 0; k < 3; k++) step("disabled_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Enable drops during HOLD: grant to 3 completes, then nothing new.
        ienable = 1'b1;
        idwell  = 8'd2;
        step("en_grant", 4'b1000, 2'd3, 1'b0, 1'b0);
        step("en_hold1", 4'b1000, 2'd3, 1'b1, 1'b0);
        ienable = 1'b0;
        step("en_done", 4'b1000, 2'd3, 1'b1, 1'b1);
        step("en_release", 4'b0000, 2'd3, 1'b0, 1'b0);
        step("en_stay_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        step("en_stay_idle2", 4'b0000, 2'd3, 1'b0, 1'b0);

`ifdef APHASE_SCHED_LOCK_EN
        // Lock held for four HOLD cycles with dwell 2: six valid cycles.
        ienable = 1'b1;
        ireq    = 4'b0001;
        idwell  = 8'd2;
        step("lock_grant", 4'b0001, 2'd0, 1'b0, 1'b0);
        step("lock_h1", 4'b0001, 2'd0, 1'b1, 1'b0);
        ilock = 1'b1;
        step("lock_h2", 4'b0001, 2'd0, 1'b1, 1'b0);
        step("lock_h3", 4'b0001, 2'd0, 1'b1, 1'b0);
        step("lock_h4", 4'b0001, 2'd0, 1'b1, 1'b0);
        step("lock_h5", 4'b0001, 2'd0, 1'b1, 1'b0);
        ilock = 1'b0;
        step("lock_h6_done", 4'b0001, 2'd0, 1'b1, 1'b1);
        ireq = 4'b0000;
        step("lock_release", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: observed %0d leftover required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
